// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: direction counter
// encodings and the saturating counter update rule.
package bpu_pkg;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   // Move a 2-bit direction counter one step toward the resolved outcome,
   // holding at the strong states.
   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      if (taken && (ctr != CTR_ST)) begin
         nxt = ctr + 2'd1;
      end else if (!taken && (ctr != CTR_SNT)) begin
         nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bpu_table.sv
// Direct-mapped BTB storage: one combinational fetch read port and one
// read-modify-write training port, with asynchronous active-low reset.
module bpu_table
   import bpu_pkg::*;
#(
   parameter int unsigned PC_W    = 9,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = $clog2(ENTRIES),
   parameter int unsigned TAG_W   = PC_W - IDX_W - 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [PC_W-1:0]  rd_target,
   output logic [1:0]       rd_ctr,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [TAG_W-1:0] upd_tag,
   input  logic             upd_taken,
   input  logic [PC_W-1:0]  upd_target
);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [1:0]       ctr;
   } btb_entry_t;

   btb_entry_t entry_q [ENTRIES];
   btb_entry_t entry_d [ENTRIES];
   btb_entry_t upd_cur;
   logic       upd_hit;

   // Fetch lookup reads the registered entry, so a same-cycle write is not bypassed.
   always_comb begin
      rd_valid  = entry_q[rd_idx].valid;
      rd_tag    = entry_q[rd_idx].tag;
      rd_target = entry_q[rd_idx].target;
      rd_ctr    = entry_q[rd_idx].ctr;
   end

   // Training: hits step the counter (and retarget on taken); taken misses allocate.
   always_comb begin
      entry_d = entry_q;
      upd_cur = entry_q[upd_idx];
      upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);
      if (upd_en) begin
         if (upd_hit) begin
            entry_d[upd_idx].ctr = sat_update(upd_cur.ctr, upd_taken);
            if (upd_taken) begin
               entry_d[upd_idx].target = upd_target;
            end
         end else if (upd_taken) begin
            entry_d[upd_idx].valid  = 1'b1;
            entry_d[upd_idx].tag    = upd_tag;
            entry_d[upd_idx].target = upd_target;
            entry_d[upd_idx].ctr    = CTR_WT;
         end
      end
   end

   // Table state register; reset leaves every entry invalid and weakly not-taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            entry_q[i].valid  <= 1'b0;
            entry_q[i].tag    <= '0;
            entry_q[i].target <= '0;
            entry_q[i].ctr    <= CTR_WNT;
         end
      end else begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: same-cycle BTB prediction for fetch, branch
// resolution and redirect for execute, table training and perf counters.
module branch_predict_unit
   import bpu_pkg::*;
#(
   parameter int unsigned PC_W    = 9,
   parameter int unsigned ENTRIES = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [PC_W-1:0] FetchPC,
   output logic            PredTaken,
   output logic [PC_W-1:0] PredTarget,
   input  logic [PC_W-1:0] ExPC,
   input  logic [31:0]     Imm,
   input  logic            Branch,
   input  logic [31:0]     ALUResult,
   input  logic            ExPredTaken,
   input  logic [PC_W-1:0] ExPredTarget,
   output logic [31:0]     PCImm,
   output logic [31:0]     PCFour,
   output logic [31:0]     BrPC,
   output logic            PCSel,
   output logic [31:0]     BranchCount,
   output logic [31:0]     MispredCount
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = PC_W - IDX_W - 2;

   logic [IDX_W-1:0] fetch_idx;
   logic [TAG_W-1:0] fetch_tag;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [PC_W-1:0]  rd_target;
   logic [1:0]       rd_ctr;
   logic [31:0]      ex_pc_ext;
   logic             taken;
   logic             mispredict;
   logic [31:0]      branch_count_d, branch_count_q;
   logic [31:0]      mispred_count_d, mispred_count_q;
   logic             unused_ok;

   assign fetch_idx = FetchPC[IDX_W+1:2];
   assign fetch_tag = FetchPC[PC_W-1:IDX_W+2];
   assign ex_idx    = ExPC[IDX_W+1:2];
   assign ex_tag    = ExPC[PC_W-1:IDX_W+2];
   assign unused_ok = ^{ALUResult[31:1], rd_ctr[0]};

   bpu_table #(
      .PC_W    (PC_W),
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W),
      .TAG_W   (TAG_W)
   ) u_table (
      .clk        (clk),
      .rst_n      (reset_n),
      .rd_idx     (fetch_idx),
      .rd_valid   (rd_valid),
      .rd_tag     (rd_tag),
      .rd_target  (rd_target),
      .rd_ctr     (rd_ctr),
      .upd_en     (Branch),
      .upd_idx    (ex_idx),
      .upd_tag    (ex_tag),
      .upd_taken  (taken),
      .upd_target (PCImm[PC_W-1:0])
   );

   // Fetch prediction: taken only on a tag hit with a taken-leaning counter.
   always_comb begin
      PredTaken  = rd_valid && (rd_tag == fetch_tag) && rd_ctr[1];
      PredTarget = PredTaken ? rd_target : FetchPC + PC_W'(4);
   end

   // Resolve: compare the actual outcome against what fetch was told.
   always_comb begin
      ex_pc_ext  = 32'(ExPC);
      PCImm      = ex_pc_ext + Imm;
      PCFour     = ex_pc_ext + 32'd4;
      taken      = ALUResult[0];
      mispredict = (taken != ExPredTaken) ||
                   (taken && (ExPredTarget != PCImm[PC_W-1:0]));
      PCSel      = Branch && mispredict;
      BrPC       = '0;
      if (PCSel) begin
         BrPC = taken ? PCImm : PCFour;
      end
   end

   // Performance counters, saturating at all-ones.
   always_comb begin
      branch_count_d  = branch_count_q;
      mispred_count_d = mispred_count_q;
      if (Branch && (branch_count_q != '1)) begin
         branch_count_d = branch_count_q + 32'd1;
      end
      if (PCSel && (mispred_count_q != '1)) begin
         mispred_count_d = mispred_count_q + 32'd1;
      end
   end

   // Counter state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branch_count_q  <= '0;
         mispred_count_q <= '0;
      end else begin
         branch_count_q  <= branch_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign BranchCount  = branch_count_q;
   assign MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed table-driven bench for branch_predict_unit (PC_W=9, ENTRIES=16).
module tb_branch_predict_unit;

   logic        clk;
   logic        reset_n;
   logic [8:0]  FetchPC;
   logic        PredTaken;
   logic [8:0]  PredTarget;
   logic [8:0]  ExPC;
   logic [31:0] Imm;
   logic        Branch;
   logic [31:0] ALUResult;
   logic        ExPredTaken;
   logic [8:0]  ExPredTarget;
   logic [31:0] PCImm;
   logic [31:0] PCFour;
   logic [31:0] BrPC;
   logic        PCSel;
   logic [31:0] BranchCount;
   logic [31:0] MispredCount;

   int checks = 0;
   int errors = 0;

   branch_predict_unit #(
      .PC_W    (9),
      .ENTRIES (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .FetchPC      (FetchPC),
      .PredTaken    (PredTaken),
      .PredTarget   (PredTarget),
      .ExPC         (ExPC),
      .Imm          (Imm),
      .Branch       (Branch),
      .ALUResult    (ALUResult),
      .ExPredTaken  (ExPredTaken),
      .ExPredTarget (ExPredTarget),
      .PCImm        (PCImm),
      .PCFour       (PCFour),
      .BrPC         (BrPC),
      .PCSel        (PCSel),
      .BranchCount  (BranchCount),
      .MispredCount (MispredCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0]  fpc;
      logic [8:0]  epc;
      logic [31:0] imm;
      logic        br;
      logic        alu;
      logic        ept;
      logic [8:0]  eptg;
      logic        pt;
      logic [8:0]  ptg;
      logic        sel;
      logic [31:0] brpc;
      logic [31:0] pcimm;
      logic [31:0] pcfour;
      logic [31:0] bc;
      logic [31:0] mc;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [8:0] fpc, input logic [8:0] epc, input logic [31:0] imm,
                        input logic br, input logic alu, input logic ept, input logic [8:0] eptg);
      FetchPC      = fpc;
      ExPC         = epc;
      Imm          = imm;
      Branch       = br;
      ALUResult    = {31'd0, alu};
      ExPredTaken  = ept;
      ExPredTarget = eptg;
   endtask

   initial begin
      // Counter columns hold the value before this row's clock edge.
      //            fpc     epc     imm           br    alu   ept   eptg    pt    ptg     sel   brpc          pcimm         pcfour      bc     mc
      vecs[0]  = '{9'h040, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h0,        32'h0,        32'h4,      32'd0, 32'd0};
      vecs[1]  = '{9'h040, 9'h040, 32'h20,       1'b1, 1'b1, 1'b0, 9'h044, 1'b0, 9'h044, 1'b1, 32'h60,       32'h60,       32'h44,     32'd0, 32'd0};
      vecs[2]  = '{9'h040, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 9'h060, 1'b0, 32'h0,        32'h0,        32'h4,      32'd1, 32'd1};
      vecs[3]  = '{9'h040, 9'h040, 32'h20,       1'b1, 1'b0, 1'b1, 9'h060, 1'b1, 9'h060, 1'b1, 32'h44,       32'h60,       32'h44,     32'd1, 32'd1};
      vecs[4]  = '{9'h040, 9'h040, 32'h20,       1'b1, 1'b0, 1'b0, 9'h044, 1'b0, 9'h044, 1'b0, 32'h0,        32'h60,       32'h44,     32'd2, 32'd2};
      vecs[5]  = '{9'h040, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h0,        32'h0,        32'h4,      32'd3, 32'd2};
      vecs[6]  = '{9'h080, 9'h080, 32'h10,       1'b1, 1'b1, 1'b0, 9'h084, 1'b0, 9'h084, 1'b1, 32'h90,       32'h90,       32'h84,     32'd3, 32'd2};
      vecs[7]  = '{9'h040, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h0,        32'h0,        32'h4,      32'd4, 32'd3};
      vecs[8]  = '{9'h080, 9'h080, 32'h10,       1'b1, 1'b1, 1'b1, 9'h090, 1'b1, 9'h090, 1'b0, 32'h0,        32'h90,       32'h84,     32'd4, 32'd3};
      vecs[9]  = '{9'h080, 9'h080, 32'h20,       1'b1, 1'b1, 1'b1, 9'h090, 1'b1, 9'h090, 1'b1, 32'hA0,       32'hA0,       32'h84,     32'd5, 32'd3};
      vecs[10] = '{9'h080, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 9'h0A0, 1'b0, 32'h0,        32'h0,        32'h4,      32'd6, 32'd4};
      vecs[11] = '{9'h1FC, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h0,        32'h0,        32'h4,      32'd6, 32'd4};
      vecs[12] = '{9'h1FC, 9'h1FC, 32'hFFFFFE00, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h200,    32'd6, 32'd4};
      vecs[13] = '{9'h1FC, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 9'h1FC, 1'b0, 32'h0,        32'h0,        32'h4,      32'd7, 32'd5};
      vecs[14] = '{9'h040, 9'h040, 32'h20,       1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h0,        32'h60,       32'h44,     32'd7, 32'd5};
      vecs[15] = '{9'h040, 9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h044, 1'b0, 32'h0,        32'h0,        32'h4,      32'd7, 32'd5};

      reset_n = 1'b0;
      drive(9'h040, 9'h000, 32'h0, 1'b0, 1'b0, 1'b0, 9'h000);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].fpc, vecs[i].epc, vecs[i].imm, vecs[i].br, vecs[i].alu,
               vecs[i].ept, vecs[i].eptg);
         #2;
         check($sformatf("v%0d PredTaken", i),    32'(PredTaken),  32'(vecs[i].pt));
         check($sformatf("v%0d PredTarget", i),   32'(PredTarget), 32'(vecs[i].ptg));
         check($sformatf("v%0d PCSel", i),        32'(PCSel),      32'(vecs[i].sel));
         check($sformatf("v%0d BrPC", i),         BrPC,            vecs[i].brpc);
         check($sformatf("v%0d PCImm", i),        PCImm,           vecs[i].pcimm);
         check($sformatf("v%0d PCFour", i),       PCFour,          vecs[i].pcfour);
         check($sformatf("v%0d BranchCount", i),  BranchCount,     vecs[i].bc);
         check($sformatf("v%0d MispredCount", i), MispredCount,    vecs[i].mc);
      end

      // Asynchronous reset mid-update, sampled before the next clock edge.
      @(negedge clk);
      drive(9'h080, 9'h080, 32'h10, 1'b1, 1'b0, 1'b1, 9'h090);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst BranchCount",  BranchCount,  32'd0);
      check("rst MispredCount", MispredCount, 32'd0);
      check("rst lookup80 PredTaken",  32'(PredTaken),  32'd0);
      check("rst lookup80 PredTarget", 32'(PredTarget), 32'h084);
      FetchPC = 9'h1FC;
      #1;
      check("rst lookup1FC PredTaken",  32'(PredTaken),  32'd0);
      check("rst lookup1FC PredTarget", 32'(PredTarget), 32'h000);
      Branch = 1'b0;
      #1;
      check("rst PCSel", 32'(PCSel), 32'd0);
      check("rst BrPC",  BrPC,       32'd0);

      // Held in reset across an edge: a taken branch must not allocate.
      drive(9'h040, 9'h040, 32'h20, 1'b1, 1'b1, 1'b0, 9'h000);
      @(negedge clk);
      #2;
      check("hold BranchCount", BranchCount, 32'd0);
      check("hold PredTaken",   32'(PredTaken), 32'd0);

      // First edge after release accepts the update.
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      Branch = 1'b0;
      #2;
      check("post PredTaken",    32'(PredTaken),  32'd1);
      check("post PredTarget",   32'(PredTarget), 32'h060);
      check("post BranchCount",  BranchCount,     32'd1);
      check("post MispredCount", MispredCount,    32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
